// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the MIPS core owns dmem by default. NREQ DMA masters
// win it through HOLD/HOLD_ACK with round-robin priority, a burst cap and a guaranteed CPU gap.
module dmem_arbiter #(
    parameter int NREQ      = 2,
    parameter int MAX_BURST = 16,
    parameter int CPU_SLOT  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_we,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wd,
    input  logic [NREQ-1:0]      dma_hold,
    input  logic [NREQ-1:0]      dma_we,
    input  logic [32*NREQ-1:0]   dma_addr,
    input  logic [32*NREQ-1:0]   dma_wd,
    output logic [NREQ-1:0]      hold_ack,
    output logic                 cpu_stall,
    output logic                 dmem_we,
    output logic [31:0]          dmem_addr,
    output logic [31:0]          dmem_wd,
    output logic [1:0]           grant_id
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int GW = $clog2(CPU_SLOT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t            r_state;
    logic [NREQ-1:0]   r_hold_ack;
    logic [1:0]        r_grant_id;
    logic [1:0]        r_rr_ptr;
    logic [BW-1:0]     r_burst_cnt;
    logic [GW-1:0]     r_gap_cnt;

    state_t            w_state_nxt;
    logic [NREQ-1:0]   w_hold_ack_nxt;
    logic [1:0]        w_grant_id_nxt;
    logic [1:0]        w_rr_ptr_nxt;
    logic [BW-1:0]     w_burst_cnt_nxt;
    logic [GW-1:0]     w_gap_cnt_nxt;

    logic              w_found_hi;
    logic              w_found_lo;
    logic [1:0]        w_win_hi;
    logic [1:0]        w_win_lo;
    logic              w_found;
    logic [1:0]        w_winner;
    logic              w_grant_live;
    logic [1:0]        w_rr_after;

    logic              w_dma_we;
    logic [31:0]       w_dma_addr;
    logic [31:0]       w_dma_wd;

    // Round-robin winner: lowest requester at/after rr_ptr, else lowest below it (wrap).
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_win_hi   = 2'd0;
        w_win_lo   = 2'd0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            w_win_hi   = (dma_hold[j] && (j >= int'(r_rr_ptr))) ? 2'(j) : w_win_hi;
            w_found_hi = w_found_hi | (dma_hold[j] && (j >= int'(r_rr_ptr)));
            w_win_lo   = (dma_hold[j] && (j < int'(r_rr_ptr))) ? 2'(j) : w_win_lo;
            w_found_lo = w_found_lo | (dma_hold[j] && (j < int'(r_rr_ptr)));
        end
        w_found  = w_found_hi | w_found_lo;
        w_winner = w_found_hi ? w_win_hi : w_win_lo;
    end

    assign w_grant_live = |(r_hold_ack & dma_hold);
    assign w_rr_after   = (r_grant_id >= 2'(NREQ - 1)) ? 2'd0 : (r_grant_id + 2'd1);

    // Next-state logic for the IDLE/GRANT/GAP arbitration sequence.
    always_comb begin
        w_state_nxt     = r_state;
        w_hold_ack_nxt  = r_hold_ack;
        w_grant_id_nxt  = r_grant_id;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_burst_cnt_nxt = r_burst_cnt;
        w_gap_cnt_nxt   = r_gap_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt     = ST_GRANT;
                    w_grant_id_nxt  = w_winner;
                    w_burst_cnt_nxt = BW'(1);
                    for (int j = 0; j < NREQ; j++) begin
                        w_hold_ack_nxt[j] = (2'(j) == w_winner);
                    end
                end else begin
                    w_hold_ack_nxt = '0;
                end
            end
            ST_GRANT: begin
                if (w_grant_live && (r_burst_cnt < BW'(MAX_BURST))) begin
                    w_burst_cnt_nxt = r_burst_cnt + BW'(1);
                end else begin
                    // Voluntary drop and burst-limit preemption take the same exit.
                    w_state_nxt    = ST_GAP;
                    w_hold_ack_nxt = '0;
                    w_rr_ptr_nxt   = w_rr_after;
                    w_gap_cnt_nxt  = GW'(CPU_SLOT);
                end
            end
            ST_GAP: begin
                w_hold_ack_nxt = '0;
                if (r_gap_cnt <= GW'(1)) begin
                    w_gap_cnt_nxt = GW'(0);
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - GW'(1);
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_hold_ack_nxt = '0;
            end
        endcase
    end

    // Arbiter state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_hold_ack  <= '0;
            r_grant_id  <= 2'd0;
            r_rr_ptr    <= 2'd0;
            r_burst_cnt <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_ack  <= w_hold_ack_nxt;
            r_grant_id  <= w_grant_id_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
        end
    end

    // One-hot AND-OR select of the acknowledged master; non-granted strobes are masked out.
    always_comb begin
        w_dma_we   = 1'b0;
        w_dma_addr = 32'd0;
        w_dma_wd   = 32'd0;
        for (int j = 0; j < NREQ; j++) begin
            w_dma_we   = w_dma_we | (r_hold_ack[j] & dma_we[j]);
            w_dma_addr = w_dma_addr | ({32{r_hold_ack[j]}} & dma_addr[32*j +: 32]);
            w_dma_wd   = w_dma_wd | ({32{r_hold_ack[j]}} & dma_wd[32*j +: 32]);
        end
    end

    assign hold_ack  = r_hold_ack;
    assign grant_id  = r_grant_id;
    assign cpu_stall = |r_hold_ack;
    assign dmem_we   = cpu_stall ? w_dma_we   : cpu_we;
    assign dmem_addr = cpu_stall ? w_dma_addr : cpu_addr;
    assign dmem_wd   = cpu_stall ? w_dma_wd   : cpu_wd;

endmodule
